// File: rtl/fp_pkg.sv
// fp_pkg: widths and state encoding shared by the fp_* decoder family.
// Holds the 13-bit float field widths, the fixed-point fraction width and
// the conversion FSM state type, plus the magnitude-load helper.
package fp_pkg;

   localparam int EXP_W      = 4;
   localparam int FRAC_W     = 8;
   localparam int FIX_FRAC_W = 8;
   // Wide enough for the largest fraction shifted by the largest exponent.
   localparam int MAG_W      = 23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } fp_state_e;

   // Place the fraction in the magnitude register so its LSB lands on the
   // fixed-point LSB weight (2^-FIX_FRAC_W).
   function automatic logic [MAG_W-1:0] load_mag(input logic [FRAC_W-1:0] frac);
      logic [MAG_W-1:0] ext;
      ext      = {{(MAG_W-FRAC_W){1'b0}}, frac};
      load_mag = ext << (FIX_FRAC_W - FRAC_W);
   endfunction

endpackage

// File: rtl/fp_to_fix_if.sv
// fp_to_fix_if: operand-in / result-out valid-ready bundle for fp_to_fix.
// slave is the converter side, master is the producer/consumer side.
interface fp_to_fix_if
   import fp_pkg::*;
#(
   parameter int OUT_W = 24
) ();

   logic              in_valid;
   logic              in_ready;
   logic              sign_in;
   logic [EXP_W-1:0]  exp_in;
   logic [FRAC_W-1:0] frac_in;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_ovf;

   modport slave (
      input  in_valid, sign_in, exp_in, frac_in, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );

   modport master (
      output in_valid, sign_in, exp_in, frac_in, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

endinterface

// File: rtl/fp_to_fix_pack.sv
// fp_to_fix_pack: turns the final unsigned magnitude and sign into the
// OUT_W-bit two's-complement word and its overflow flag.
// Build option FP_TO_FIX_SAT_EN: saturate on overflow instead of wrapping.
module fp_to_fix_pack
   import fp_pkg::*;
#(
   parameter int OUT_W = 24
) (
   input  logic [MAG_W-1:0] mag_i,
   input  logic             sign_i,
   input  logic             zero_i,
   output logic [OUT_W-1:0] data_o,
   output logic             ovf_o
);

   localparam logic [MAG_W:0] ONE_C     = {{MAG_W{1'b0}}, 1'b1};
   // Largest representable negative magnitude is 2^(OUT_W-1).
   localparam logic [MAG_W:0] NEG_LIM_C = ONE_C << (OUT_W - 1);
   localparam logic [MAG_W:0] POS_LIM_C = NEG_LIM_C - ONE_C;
   localparam logic [OUT_W-1:0] SAT_POS_C = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG_C = {1'b1, {(OUT_W-1){1'b0}}};

   logic [MAG_W:0] mag_ext_s;
   logic [MAG_W:0] exact_s;
   logic           neg_s;

   // A zero fraction always yields +0, so the sign is dropped for it.
   assign mag_ext_s = {1'b0, mag_i};
   assign neg_s     = sign_i & ~zero_i;

   // Exact signed value, range check against the word limits, and the
   // overflow policy (saturate or keep the low OUT_W bits).
   always_comb begin
      exact_s = mag_ext_s;
      ovf_o   = 1'b0;
      data_o  = {OUT_W{1'b0}};
      if (neg_s) begin
         exact_s = (~mag_ext_s) + ONE_C;
         ovf_o   = (mag_ext_s > NEG_LIM_C);
      end else begin
         exact_s = mag_ext_s;
         ovf_o   = (mag_ext_s > POS_LIM_C);
      end
`ifdef FP_TO_FIX_SAT_EN
      if (ovf_o) begin
         if (neg_s) begin
            data_o = SAT_NEG_C;
         end else begin
            data_o = SAT_POS_C;
         end
      end else begin
         data_o = exact_s[OUT_W-1:0];
      end
`else
      data_o = exact_s[OUT_W-1:0];
`endif
   end

endmodule

// File: rtl/fp_to_fix.sv
// fp_to_fix: iterative 13-bit float to signed fixed-point (8 fractional
// bits) converter. One left shift per cycle, exp shifts per operand.
// Build option FP_TO_FIX_SAT_EN selects saturation on overflow (see
// fp_to_fix_pack); otherwise overflowing results wrap.
module fp_to_fix
   import fp_pkg::*;
#(
   parameter int OUT_W = 24
) (
   input  logic        clk,
   input  logic        reset,
   fp_to_fix_if.slave  bus
);

   localparam logic [EXP_W-1:0] CNT_LAST_C = {{(EXP_W-1){1'b0}}, 1'b1};

   fp_state_e         state_q,     state_d;
   logic              sign_q,      sign_d;
   logic              zero_q,      zero_d;
   logic [MAG_W-1:0]  mag_q,       mag_d;
   logic [EXP_W-1:0]  cnt_q,       cnt_d;
   logic              in_ready_q,  in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q,  out_data_d;
   logic              out_ovf_q,   out_ovf_d;

   logic [OUT_W-1:0]  pack_data_s;
   logic              pack_ovf_s;

   // The packer sees the next-state magnitude so the result can be
   // registered on the very edge that enters DONE.
   fp_to_fix_pack #(
      .OUT_W (OUT_W)
   ) u_pack (
      .mag_i  (mag_d),
      .sign_i (sign_d),
      .zero_i (zero_d),
      .data_o (pack_data_s),
      .ovf_o  (pack_ovf_s)
   );

   // Next-state, datapath and handshake-output logic of the conversion FSM.
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      zero_d      = zero_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sign_d     = bus.sign_in;
               zero_d     = (bus.frac_in == {FRAC_W{1'b0}});
               mag_d      = load_mag(bus.frac_in);
               cnt_d      = bus.exp_in;
               in_ready_d = 1'b0;
               if (bus.exp_in == {EXP_W{1'b0}}) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = pack_data_s;
                  out_ovf_d   = pack_ovf_s;
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d    = IDLE;
               in_ready_d = 1'b1;
            end
         end
         SHIFT: begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - CNT_LAST_C;
            if (cnt_q == CNT_LAST_C) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_data_d  = pack_data_s;
               out_ovf_d   = pack_ovf_s;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            // No new operand is taken on the result handshake edge.
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         mag_q       <= {MAG_W{1'b0}};
         cnt_q       <= {EXP_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= {OUT_W{1'b0}};
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         zero_q      <= zero_d;
         mag_q       <= mag_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp_to_fix.sv
// tb_fp_to_fix: drives one stimulus stream into an OUT_W=24 and an
// OUT_W=16 converter in parallel; expected results (both widths) are
// queued on accept and popped by a monitor when results appear.
module tb_fp_to_fix;
   import fp_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       sign_v = 1'b0;
   logic [3:0] exp_v = 4'd0;
   logic [7:0] frac_v = 8'd0;
   logic       out_ready = 1'b1;

   always #5 clk = ~clk;

   fp_to_fix_if #(.OUT_W(24)) bus24 ();
   fp_to_fix_if #(.OUT_W(16)) bus16 ();

   assign bus24.in_valid  = in_valid;
   assign bus24.sign_in   = sign_v;
   assign bus24.exp_in    = exp_v;
   assign bus24.frac_in   = frac_v;
   assign bus24.out_ready = out_ready;
   assign bus16.in_valid  = in_valid;
   assign bus16.sign_in   = sign_v;
   assign bus16.exp_in    = exp_v;
   assign bus16.frac_in   = frac_v;
   assign bus16.out_ready = out_ready;

   fp_to_fix #(.OUT_W(24)) dut24 (.clk(clk), .reset(reset), .bus(bus24));
   fp_to_fix #(.OUT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   typedef struct {
      logic [23:0] d24;
      logic        o24;
      logic [15:0] d16;
      logic        o16;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   bit   have = 1'b0;
   bit   fin_done = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   // 0: normal scoreboard, 1: idle/reset values, 2: no result allowed, 3: final
   int   mode = 0;

`ifdef FP_TO_FIX_SAT_EN
   localparam logic [15:0] V4_D16  = 16'h7FFF;
   localparam logic [15:0] V8_D16  = 16'h7FFF;
   localparam logic [15:0] V10_D16 = 16'h8000;
`else
   localparam logic [15:0] V4_D16  = 16'h0000;
   localparam logic [15:0] V8_D16  = 16'h8000;
   localparam logic [15:0] V10_D16 = 16'h7F00;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            case (mode)
               1: begin
                  chk("idle_in_ready24", 32'(bus24.in_ready), 32'd1);
                  chk("idle_in_ready16", 32'(bus16.in_ready), 32'd1);
                  chk("idle_out_valid24", 32'(bus24.out_valid), 32'd0);
                  chk("idle_out_valid16", 32'(bus16.out_valid), 32'd0);
                  chk("idle_out_data24", 32'(bus24.out_data), 32'd0);
                  chk("idle_out_data16", 32'(bus16.out_data), 32'd0);
                  chk("idle_out_ovf24", 32'(bus24.out_ovf), 32'd0);
                  chk("idle_out_ovf16", 32'(bus16.out_ovf), 32'd0);
               end
               2: begin
                  chk("no_valid24", 32'(bus24.out_valid), 32'd0);
                  chk("no_valid16", 32'(bus16.out_valid), 32'd0);
               end
               3: begin
                  if (!fin_done) begin
                     chk("queue_drained", 32'(sb_q.size()) + 32'(have), 32'd0);
                     fin_done = 1'b1;
                  end
               end
               default: begin
                  if (bus24.out_valid || bus16.out_valid) begin
                     if (!have) begin
                        if (sb_q.size() == 0) begin
                           checks++;
                           errors++;
                           $display("FAIL unexpected_valid: got out_valid=1 expected no result (cycle %0d)", cyc);
                        end else begin
                           cur  = sb_q.pop_front();
                           have = 1'b1;
                           chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        end
                     end
                     if (have) begin
                        chk("out_valid24", 32'(bus24.out_valid), 32'd1);
                        chk("out_valid16", 32'(bus16.out_valid), 32'd1);
                        chk("out_data24", 32'(bus24.out_data), 32'(cur.d24));
                        chk("out_ovf24", 32'(bus24.out_ovf), 32'(cur.o24));
                        chk("out_data16", 32'(bus16.out_data), 32'(cur.d16));
                        chk("out_ovf16", 32'(bus16.out_ovf), 32'(cur.o16));
                        chk("in_ready_done24", 32'(bus24.in_ready), 32'd0);
                        chk("in_ready_done16", 32'(bus16.in_ready), 32'd0);
                        if (out_ready) have = 1'b0;
                     end
                  end
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic s, input logic [3:0] e, input logic [7:0] f,
                        input logic [23:0] d24, input logic o24,
                        input logic [15:0] d16, input logic o16, input bit push);
      exp_t ent;
      int   t;
      sign_v   = s;
      exp_v    = e;
      frac_v   = f;
      in_valid = 1'b1;
      t = 0;
      while (!bus24.in_ready && t < 200) begin
         tick();
         t++;
      end
      if (!bus24.in_ready) begin
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
         $fatal(1, "accept wait expired");
      end
      ent.d24 = d24;
      ent.o24 = o24;
      ent.d16 = d16;
      ent.o16 = o16;
      ent.acc = cyc;
      ent.lat = int'(e) + 1;
      if (push) sb_q.push_back(ent);
      tick();
      // Operands are scrambled while busy; the converter must ignore them.
      in_valid = 1'b0;
      sign_v   = ~s;
      exp_v    = ~e;
      frac_v   = ~f;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || have) && t < 300) begin
         tick();
         t++;
      end
      if (sb_q.size() != 0 || have) begin
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
         $fatal(1, "drain wait expired");
      end
   endtask

   initial begin
      int t;
      repeat (3) tick();
      reset = 1'b0;
      mode  = 1;
      tick();
      mode  = 0;

      //     s     e      f       d24          o24   d16      o16
      issue(1'b0, 4'd1,  8'h80, 24'h000100, 1'b0, 16'h0100, 1'b0, 1'b1);
      issue(1'b1, 4'd0,  8'hC0, 24'hFFFF40, 1'b0, 16'hFF40, 1'b0, 1'b1);
      issue(1'b1, 4'd15, 8'hFF, 24'h808000, 1'b0, 16'h8000, 1'b1, 1'b1);
      issue(1'b0, 4'd9,  8'h80, 24'h010000, 1'b0, V4_D16,   1'b1, 1'b1);
      issue(1'b1, 4'd5,  8'h00, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b1);
      wait_drain();

      // Consumer stalls for several cycles while the result is presented.
      out_ready = 1'b0;
      issue(1'b0, 4'd3, 8'hA5, 24'h000528, 1'b0, 16'h0528, 1'b0, 1'b1);
      t = 0;
      while (!bus24.out_valid && t < 50) begin
         tick();
         t++;
      end
      repeat (3) tick();
      out_ready = 1'b1;
      wait_drain();

      issue(1'b1, 4'd8, 8'h80, 24'hFF8000, 1'b0, 16'h8000, 1'b0, 1'b1);
      issue(1'b0, 4'd8, 8'h80, 24'h008000, 1'b0, V8_D16,   1'b1, 1'b1);
      issue(1'b0, 4'd7, 8'hFF, 24'h007F80, 1'b0, 16'h7F80, 1'b0, 1'b1);
      issue(1'b1, 4'd8, 8'h81, 24'hFF7F00, 1'b0, V10_D16,  1'b1, 1'b1);
      issue(1'b0, 4'd2, 8'h01, 24'h000004, 1'b0, 16'h0004, 1'b0, 1'b1);
      issue(1'b1, 4'd0, 8'h00, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b1);
      wait_drain();

      // Reset in the middle of a long conversion discards it.
      issue(1'b0, 4'd10, 8'h80, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mode  = 1;
      tick();
      mode  = 2;
      repeat (20) tick();
      mode  = 0;

      issue(1'b0, 4'd4, 8'h10, 24'h000100, 1'b0, 16'h0100, 1'b0, 1'b1);
      wait_drain();

      mode = 3;
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
